// File: rtl/xor_crc_engine_if.sv
// xor_crc_engine_if: beat stream in, checksum out, shared by source and engine
interface xor_crc_engine_if #(
   parameter int CRC_W  = 8,
   parameter int DATA_W = 8
);
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              busy;
   logic              crc_valid;
   logic [CRC_W-1:0]  crc_out;
   modport master (output start, in_valid, in_data, in_last,
                   input  in_ready, busy, crc_valid, crc_out);
   modport slave  (input  start, in_valid, in_data, in_last,
                   output in_ready, busy, crc_valid, crc_out);
endinterface

// File: rtl/xor_crc_engine.sv
// xor_crc_engine: folds DATA_W-bit beats, MSB first, into a CRC_W-bit non-reflected CRC
module xor_crc_engine #(
   parameter int               CRC_W   = 8,
   parameter int               DATA_W  = 8,
   parameter logic [CRC_W-1:0] POLY    = 'h07,
   parameter logic [CRC_W-1:0] INIT    = '0,
   parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
   input logic              clk,
   input logic              rst,
   xor_crc_engine_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state;
   logic [CRC_W-1:0] r_crc;
   logic [CRC_W-1:0] r_out;
   logic             r_ready;
   logic             r_busy;
   logic             r_valid;
   logic [CRC_W-1:0] w_next;
   logic             w_accept;
   // whole beat folded in one cycle: DATA_W serial LFSR steps unrolled
   always_comb begin
      w_next = r_crc;
      for (int i = DATA_W - 1; i >= 0; i--)
         w_next = {w_next[CRC_W-2:0], 1'b0} ^ ((w_next[CRC_W-1] ^ bus.in_data[i]) ? POLY : '0);
   end
   assign w_accept = bus.in_valid && r_ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_crc   <= INIT;
         r_out   <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_crc   <= INIT;
               r_state <= RUN;
               r_ready <= 1'b1;
               r_busy  <= 1'b1;
            end
            RUN: if (w_accept) begin
               r_crc <= w_next;
               if (bus.in_last) begin
                  r_out   <= w_next ^ XOR_OUT;
                  r_state <= DONE;
                  r_ready <= 1'b0;
                  r_valid <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end
   assign bus.in_ready  = r_ready;
   assign bus.busy      = r_busy;
   assign bus.crc_valid = r_valid;
   assign bus.crc_out   = r_out;
endmodule

// File: tb/tb_xor_crc_engine.sv
// tb_xor_crc_engine: directed CRC-8 and CRC-16/CCITT-FALSE frames with known check values
module tb_xor_crc_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
   always #5 clk = ~clk;
   xor_crc_engine_if #(.CRC_W(8),  .DATA_W(8)) b8 ();
   xor_crc_engine_if #(.CRC_W(16), .DATA_W(8)) b16 ();
   xor_crc_engine #(.CRC_W(8), .DATA_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00))
      dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
   xor_crc_engine #(.CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000))
      dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic start8;
      b8.start = 1'b1;
      tick();
      b8.start = 1'b0;
   endtask
   task automatic beat8(input logic [7:0] d, input logic l);
      b8.in_valid = 1'b1;
      b8.in_data  = d;
      b8.in_last  = l;
      tick();
      b8.in_valid = 1'b0;
      b8.in_last  = 1'b0;
   endtask
   task automatic test_reset;
      repeat (2) @(posedge clk);
      #2;
      n_cmp++; if (b8.crc_out !== 8'h00) begin n_err++; $display("FAIL reset_crc_out: got %h want 00", b8.crc_out); end
      n_cmp++; if (b8.crc_valid !== 1'b0) begin n_err++; $display("FAIL reset_crc_valid: got %b want 0", b8.crc_valid); end
      n_cmp++; if (b8.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", b8.in_ready); end
      n_cmp++; if (b8.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", b8.busy); end
      rst = 1'b0;
      tick();
      n_cmp++; if (b8.in_ready !== 1'b0) begin n_err++; $display("FAIL idle_in_ready: got %b want 0", b8.in_ready); end
   endtask
   task automatic test_check_string(input int gap);
      start8();
      n_cmp++; if (b8.in_ready !== 1'b1 || b8.busy !== 1'b1) begin n_err++; $display("FAIL run_entry gap=%0d: ready=%b busy=%b want 1 1", gap, b8.in_ready, b8.busy); end
      for (int i = 0; i < 9; i++) begin
         if (i == 4)
            repeat (gap) begin
               tick();
               n_cmp++; if (b8.in_ready !== 1'b1 || b8.crc_valid !== 1'b0) begin n_err++; $display("FAIL bubble: ready=%b valid=%b want 1 0", b8.in_ready, b8.crc_valid); end
            end
         beat8(msg[i], i == 8);
         if (i < 8) begin
            n_cmp++; if (b8.crc_valid !== 1'b0) begin n_err++; $display("FAIL early_valid beat %0d: got %b want 0", i, b8.crc_valid); end
         end
      end
      n_cmp++; if (b8.crc_valid !== 1'b1) begin n_err++; $display("FAIL str_valid gap=%0d: got %b want 1", gap, b8.crc_valid); end
      n_cmp++; if (b8.crc_out !== 8'hF4) begin n_err++; $display("FAIL str_crc gap=%0d: got %h want f4", gap, b8.crc_out); end
      n_cmp++; if (b8.in_ready !== 1'b0 || b8.busy !== 1'b1) begin n_err++; $display("FAIL done_flags: ready=%b busy=%b want 0 1", b8.in_ready, b8.busy); end
      tick();
      n_cmp++; if (b8.crc_valid !== 1'b0 || b8.busy !== 1'b0) begin n_err++; $display("FAIL pulse_end: valid=%b busy=%b want 0 0", b8.crc_valid, b8.busy); end
      n_cmp++; if (b8.crc_out !== 8'hF4) begin n_err++; $display("FAIL str_hold: got %h want f4", b8.crc_out); end
   endtask
   task automatic test_single_beat;
      start8();
      beat8(8'h01, 1'b1);
      n_cmp++; if (b8.crc_valid !== 1'b1 || b8.crc_out !== 8'h07) begin n_err++; $display("FAIL single_01: valid=%b crc=%h want 1 07", b8.crc_valid, b8.crc_out); end
      repeat (3) tick();
      start8();
      n_cmp++; if (b8.crc_out !== 8'h07) begin n_err++; $display("FAIL hold_over_start: got %h want 07", b8.crc_out); end
      beat8(8'h00, 1'b1);
      n_cmp++; if (b8.crc_valid !== 1'b1 || b8.crc_out !== 8'h00) begin n_err++; $display("FAIL single_00: valid=%b crc=%h want 1 00", b8.crc_valid, b8.crc_out); end
      b8.start = 1'b1;
      tick();
      b8.start = 1'b0;
      tick();
      n_cmp++; if (b8.busy !== 1'b0 || b8.in_ready !== 1'b0) begin n_err++; $display("FAIL start_in_done: busy=%b ready=%b want 0 0", b8.busy, b8.in_ready); end
   endtask
   task automatic test_start_with_valid;
      b8.start    = 1'b1;
      b8.in_valid = 1'b1;
      b8.in_data  = 8'hFF;
      b8.in_last  = 1'b1;
      tick();
      b8.start    = 1'b0;
      b8.in_valid = 1'b0;
      b8.in_last  = 1'b0;
      n_cmp++; if (b8.in_ready !== 1'b1 || b8.crc_valid !== 1'b0) begin n_err++; $display("FAIL start_valid_ignored: ready=%b valid=%b want 1 0", b8.in_ready, b8.crc_valid); end
      beat8(8'h01, 1'b1);
      n_cmp++; if (b8.crc_valid !== 1'b1 || b8.crc_out !== 8'h07) begin n_err++; $display("FAIL after_start_valid: valid=%b crc=%h want 1 07", b8.crc_valid, b8.crc_out); end
      tick();
   endtask
   task automatic test_reset_mid_frame;
      start8();
      for (int i = 0; i < 4; i++) beat8(msg[i], 1'b0);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (b8.busy !== 1'b0 || b8.in_ready !== 1'b0) begin n_err++; $display("FAIL abort_flags: busy=%b ready=%b want 0 0", b8.busy, b8.in_ready); end
      n_cmp++; if (b8.crc_out !== 8'h00) begin n_err++; $display("FAIL abort_crc_out: got %h want 00", b8.crc_out); end
      tick();
      rst = 1'b0;
      repeat (2) begin
         tick();
         n_cmp++; if (b8.crc_valid !== 1'b0 || b8.busy !== 1'b0) begin n_err++; $display("FAIL abort_quiet: valid=%b busy=%b want 0 0", b8.crc_valid, b8.busy); end
      end
      start8();
      beat8(8'h01, 1'b1);
      n_cmp++; if (b8.crc_valid !== 1'b1 || b8.crc_out !== 8'h07) begin n_err++; $display("FAIL post_abort: valid=%b crc=%h want 1 07", b8.crc_valid, b8.crc_out); end
      tick();
   endtask
   task automatic test_crc16;
      b16.start = 1'b1;
      tick();
      b16.start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         b16.in_valid = 1'b1;
         b16.in_data  = msg[i];
         b16.in_last  = (i == 8);
         tick();
      end
      b16.in_valid = 1'b0;
      b16.in_last  = 1'b0;
      n_cmp++; if (b16.crc_valid !== 1'b1 || b16.crc_out !== 16'h29B1) begin n_err++; $display("FAIL crc16: valid=%b crc=%h want 1 29b1", b16.crc_valid, b16.crc_out); end
      tick();
   endtask
   initial begin
      b8.start  = 1'b0; b8.in_valid  = 1'b0; b8.in_data  = '0; b8.in_last  = 1'b0;
      b16.start = 1'b0; b16.in_valid = 1'b0; b16.in_data = '0; b16.in_last = 1'b0;
      test_reset();
      test_check_string(0);
      test_single_beat();
      test_check_string(3);
      test_start_with_valid();
      test_reset_mid_frame();
      test_crc16();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/xor_crc_engine.md
Name: xor_crc_engine

Overview:
- Parametrised, clocked successor to the single-gate XOR cell: an XOR-network CRC engine that folds a stream of DATA_W-bit beats into a CRC_W-bit checksum.
- Sits between a byte/word stream source and a framing/checker block.
- Uses a valid/ready handshake with explicit start and last markers, and holds the final CRC until the next frame starts.

Parameters:
- CRC_W, 8, CRC register width in bits (min 2).
- DATA_W, 8, bits consumed per accepted beat (min 1).
- POLY, 8'h07, generator polynomial (CRC_W bits, implicit x^CRC_W term, non-reflected).
- INIT, 0, CRC register value loaded on start.
- XOR_OUT, 0, value XORed into the register to form crc_out.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin new frame; sampled only in IDLE.
- in_valid  input  1  in_data/in_last are valid this cycle.
- in_ready  output  1  engine accepts a beat this cycle.
- in_data  input  DATA_W  data beat, MSB processed first.
- in_last  input  1  marks final beat of frame.
- busy  output  1  high in RUN and DONE.
- crc_valid  output  1  one-cycle pulse: crc_out holds a new result.
- crc_out  output  CRC_W  final CRC (register ^ XOR_OUT).

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. On reset, state=IDLE, CRC register=INIT, crc_out=0, crc_valid=0, in_ready=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 at a clk edge: register<=INIT, go to RUN.
  - in_valid is ignored in IDLE, including when it is asserted in the same cycle as start.
- RUN:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready.
  - On acceptance the register is updated in the same edge by DATA_W serial steps, MSB of in_data first. Each step: fb=reg[CRC_W-1]^d; reg=(reg<<1) ^ (fb ? POLY : 0), truncated to CRC_W bits. The steps are unrolled combinationally: one beat per cycle, no stall.
  - in_valid=0 is a bubble: register holds, no timeout.
  - An accepted beat with in_last=1 moves the FSM to DONE.
  - start is ignored in RUN.
- DONE:
  - Lasts exactly one cycle; in_ready=0.
  - crc_valid=1; crc_out=register^XOR_OUT, registered at entry to DONE.
  - Latency: crc_valid is high exactly 1 cycle after the edge that accepted the last beat.
  - Next state is IDLE unconditionally; start asserted during DONE is ignored.
- crc_out holds its value after DONE until the next DONE or reset. It is not cleared by start.
- Single-beat frame (start, then one beat with in_last=1) is legal.
- crc_valid never asserts without at least one accepted beat.
- Reset mid-frame aborts the frame immediately (asynchronous). No crc_valid is produced for the aborted frame.
- All outputs are driven from registers or the state decode; no combinational path from in_data to any output.

Test Plan:
- Defaults; rst for 20 ns, then start, then ASCII "123456789" (0x31..0x39) as 9 beats, in_last on 0x39 -> crc_valid pulses 1 cycle after the last beat; crc_out=0xF4.
- Defaults; single beat 0x01 with in_last -> crc_out=0x07. Single beat 0x00 -> crc_out=0x00.
- Same "123456789" frame with in_valid deasserted for 3 cycles between beats 4 and 5 -> result still 0xF4; register is unchanged during the bubbles.
- Assert start and in_valid together in IDLE with in_data=0xFF -> no beat accepted that cycle (in_ready=0). A following frame with beat 0x01 gives 0x07.
- Assert rst mid-frame after 4 beats, then run a fresh frame with beat 0x01 -> no crc_valid for the aborted frame; crc_out=0 after reset; new result 0x07.
- CRC_W=16, DATA_W=8, POLY=16'h1021, INIT=16'hFFFF (CRC-16/CCITT-FALSE); frame "123456789" -> crc_out=0x29B1.
